st_seq_ctrl: RTL and testbench
==============================

// Module: st_seq_ctrl
// PURPOSE
//  Frame sequencer for the self-test datapath, clocked on div_8_clk.
//  Sits between eight_to_thirty_two and self_test/thirty_two_to_eight:
//  - hunts for a sync word on the 32-bit word stream
//  - loads FRAME_WORDS payload words into self_test
//  - waits for sort_finish, then drives tx_out for exactly FRAME_WORDS result words.
//  Non-first layers (f_layer=0) bypass the sort stage and forward the payload.
// PARAMETERS
//  FRAME_WORDS  8             payload words per frame; must be >=2
//  SYNC_WORD    32'hA5A5_5A5A frame header word
//  TIMEOUT_CYC  1024          max cycles in SORT before error (timeout build only)
//  IDX_W        $clog2(FRAME_WORDS)  load/transmit index width
// PORTS
//  div_8_clk    in   1      sole clock
//  rst          in   1      asynchronous, active-high reset
//  f_layer      in   1      1 = first layer (sort), 0 = forward; sampled in IDLE only
//  start        in   1      arm the sequencer; level or pulse
//  word_vld     in   1      word_in valid this cycle
//  word_in      in   32     deserialized word
//  sort_finish  in   1      self_test completion, level
//  st_data_in   in   32     self_test result word
//  load_en      out  1      payload word presented to self_test
//  load_idx     out  IDX_W  payload index of load_en word
//  load_data    out  32     payload word (registered word_in)
//  tx_out       out  1      transmit qualifier to thirty_two_to_eight
//  tx_data      out  32     transmit word
//  busy         out  1      state != IDLE
//  done         out  1      1-cycle pulse after last tx word
//  err          out  1      sticky; cleared only by rst or start in IDLE
//  frame_cnt    out  8      frames completed, wraps 255->0
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; all counters 0. Reset mid-frame aborts immediately.
//  - FSM states:
//    - IDLE: on start -> HUNT; latch f_layer; clear err.
//    - HUNT: word_vld && word_in==SYNC_WORD -> LOAD; other words dropped.
//    - LOAD: each word_vld word -> load_en=1 next cycle with load_idx=count, count++.
//      At count==FRAME_WORDS-1 with word_vld: go to SORT if f_layer=1, else XMIT.
//      Gaps in word_vld are allowed; the state holds.
//      A SYNC_WORD inside LOAD counts as payload; no resync.
//    - SORT: first cycle with sort_finish=1 -> XMIT.
//    - XMIT: tx_out=1 for FRAME_WORDS consecutive cycles.
//      tx_data = st_data_in (sort path) or the buffered payload[idx] (forward path).
//      Then -> IDLE with done=1 for one cycle and frame_cnt++.
//  - Forward path buffers FRAME_WORDS x 32 payload words in a register file.
//  - Latency, forward path: last payload word_vld to first tx_out = 2 cycles.
//  - Latency, sort path: sort_finish sampled high to first tx_out = 1 cycle.
//  - start while busy: ignored. start held high: re-arms from IDLE the cycle after done.
//  - sort_finish already high on SORT entry: XMIT next cycle.
//  - word_vld during SORT/XMIT: dropped; err set (overrun).
//  - FRAME_WORDS counter compare uses IDX_W+1 bits; no wrap inside a frame.
// CONFIGURATION
//  ST_SEQ_TIMEOUT_EN defined:
//  - SORT counts cycles; reaching TIMEOUT_CYC without sort_finish sets err, -> IDLE.
//  - No done pulse; frame_cnt unchanged.
//  ST_SEQ_TIMEOUT_EN undefined: no counter; SORT waits indefinitely.
// STRUCTURE
//  - st_seq_pkg: state enum (IDLE,HUNT,LOAD,SORT,XMIT) and the SYNC_WORD default
//    constant; shared with the bench.
//  - One sub-module: st_frame_buf, the FRAME_WORDS x 32 write-index/read-index register
//    file for the forward path.
//  - FSM, counters and the timeout stay in st_seq_ctrl.
// TESTING
//  - Sort path: f_layer=1, start, SYNC + 8 words 1..8, sort_finish 5 cycles later
//    -> load_idx 0..7; tx_out high 8 cycles carrying st_data_in; done pulse; frame_cnt=1.
//  - Forward path: f_layer=0, SYNC + 8 words with 2-cycle word_vld gaps
//    -> tx_data = the 8 words in order, first one 2 cycles after the last input.
//  - Hunt: 3 junk words, then SYNC -> no load_en before SYNC; the first payload word
//    after SYNC has load_idx=0.
//  - Reset mid-LOAD at idx 4 -> all outputs 0 next edge; a new frame loads from idx 0.
//  - Overrun: word_vld during XMIT -> err=1 and stays set; cleared by the next start.
//  - Timeout build: sort_finish never asserted -> err at TIMEOUT_CYC, IDLE, no done.
//    Non-timeout build: stays in SORT.

Source files
------------

// File: rtl/st_seq_pkg.sv
// Shared types and constants for the self-test frame sequencer.
package st_seq_pkg;

    localparam int unsigned DataW = 32;
    localparam logic [DataW-1:0] SyncWordDefault = 32'hA5A5_5A5A;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHunt = 3'd1,
        StLoad = 3'd2,
        StSort = 3'd3,
        StXmit = 3'd4
    } st_state_e;

endpackage

// File: rtl/st_frame_buf.sv
// Payload register file for the forward path: one write port, one async read port.
module st_frame_buf
    import st_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DataW-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DataW-1:0] rd_data
);

    logic [DataW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/st_seq_ctrl.sv
// Frame sequencer: sync hunt, payload load, sort wait and transmit of FRAME_WORDS words.
// Define ST_SEQ_TIMEOUT_EN to bound the SORT wait to TIMEOUT_CYC cycles.
module st_seq_ctrl
    import st_seq_pkg::*;
#(
    parameter int unsigned      FRAME_WORDS = 8,
    parameter logic [DataW-1:0] SYNC_WORD   = SyncWordDefault,
    parameter int unsigned      TIMEOUT_CYC = 1024,
    parameter int unsigned      IDX_W       = $clog2(FRAME_WORDS)
) (
    input  logic             div_8_clk,
    input  logic             rst,
    input  logic             f_layer,
    input  logic             start,
    input  logic             word_vld,
    input  logic [DataW-1:0] word_in,
    input  logic             sort_finish,
    input  logic [DataW-1:0] st_data_in,
    output logic             load_en,
    output logic [IDX_W-1:0] load_idx,
    output logic [DataW-1:0] load_data,
    output logic             tx_out,
    output logic [DataW-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned     CntW    = IDX_W + 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_WORDS - 1);

    if (FRAME_WORDS < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("st_seq_ctrl: FRAME_WORDS must be >= 2 and TIMEOUT_CYC >= 1");
    end

    st_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  tx_idx_q, tx_idx_d;
    logic             f_layer_q, f_layer_d;
    logic             prime_q, prime_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             load_en_q;
    logic [IDX_W-1:0] load_idx_q;
    logic [DataW-1:0] load_data_q;
    logic             tx_active;
    logic [DataW-1:0] buf_rd;

`ifdef ST_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    // Forward path spends one prime cycle in XMIT so the last payload word lands in the buffer.
    assign tx_active = (state_q == StXmit) && !prime_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_idx_d    = tx_idx_q;
        f_layer_d   = f_layer_q;
        prime_d     = 1'b0;
        err_d       = err_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
`ifdef ST_SEQ_TIMEOUT_EN
        tmo_d       = (state_q == StSort) ? tmo_q + 1'b1 : '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StHunt;
                    f_layer_d = f_layer;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    tx_idx_d  = '0;
                end
            end
            StHunt: begin
                if (word_vld && word_in == SYNC_WORD) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (word_vld) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        if (f_layer_q) begin
                            state_d = StSort;
                        end else begin
                            state_d = StXmit;
                            prime_d = 1'b1;
                        end
                    end
                end
            end
            StSort: begin
                if (word_vld) begin
                    err_d = 1'b1;
                end
                if (sort_finish) begin
                    state_d = StXmit;
                end
`ifdef ST_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
`endif
            end
            StXmit: begin
                if (word_vld) begin
                    err_d = 1'b1;
                end
                if (tx_active) begin
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q == LastIdx) begin
                        state_d     = StIdle;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tx_idx_q    <= '0;
            f_layer_q   <= 1'b0;
            prime_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            load_en_q   <= 1'b0;
            load_idx_q  <= '0;
            load_data_q <= '0;
`ifdef ST_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_idx_q    <= tx_idx_d;
            f_layer_q   <= f_layer_d;
            prime_q     <= prime_d;
            err_q       <= err_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            load_en_q   <= (state_q == StLoad) && word_vld;
`ifdef ST_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
            if ((state_q == StLoad) && word_vld) begin
                load_idx_q  <= cnt_q[IDX_W-1:0];
                load_data_q <= word_in;
            end
        end
    end

    st_frame_buf #(
        .DEPTH (FRAME_WORDS),
        .IDX_W (IDX_W)
    ) u_frame_buf (
        .clk     (div_8_clk),
        .rst     (rst),
        .wr_en   (load_en_q),
        .wr_idx  (load_idx_q),
        .wr_data (load_data_q),
        .rd_idx  (tx_idx_q[IDX_W-1:0]),
        .rd_data (buf_rd)
    );

    assign load_en   = load_en_q;
    assign load_idx  = load_idx_q;
    assign load_data = load_data_q;
    assign tx_out    = tx_active;
    assign tx_data   = !tx_active ? '0 : (f_layer_q ? st_data_in : buf_rd);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_st_seq_ctrl.sv
// Self-checking bench for st_seq_ctrl: payload-queue model plus directed frames.
// Timeout expectations follow ST_SEQ_TIMEOUT_EN.
module tb_st_seq_ctrl;
    import st_seq_pkg::*;

    localparam int FW  = 8;
    localparam int TMO = 64;
    localparam logic [31:0] SYNC = SyncWordDefault;
    localparam int PIdle = 0, PHunt = 1, PLoad = 2, PSort = 3, PXmit = 4;

    logic        clk = 1'b0, rst = 1'b1, f_layer = 1'b0, start = 1'b0;
    logic        word_vld = 1'b0, sort_finish = 1'b0;
    logic [31:0] word_in = '0, st_data_in = '0;
    logic        load_en, tx_out, busy, done, err;
    logic [2:0]  load_idx;
    logic [31:0] load_data, tx_data;
    logic [7:0]  frame_cnt;

    int n_pass = 0, n_tot = 0;

    st_seq_ctrl #(
        .FRAME_WORDS (FW),
        .SYNC_WORD   (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .div_8_clk   (clk),
        .rst         (rst),
        .f_layer     (f_layer),
        .start       (start),
        .word_vld    (word_vld),
        .word_in     (word_in),
        .sort_finish (sort_finish),
        .st_data_in  (st_data_in),
        .load_en     (load_en),
        .load_idx    (load_idx),
        .load_data   (load_data),
        .tx_out      (tx_out),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        st_data_in = $urandom;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Model: frame phase, payload queue and counters derived from the frame rules.
    int          ph = PIdle, gap_m = 0, tx_k = 0, sort_cyc = 0, m_idx = 0, m_frames = 0;
    bit          fwd = 1'b0, m_err = 1'b0, m_load_en = 1'b0, m_done = 1'b0, tx_exp = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] pay [$];

    initial forever begin
        @(posedge clk);
        m_load_en = 1'b0;
        m_done    = 1'b0;
        if (rst) begin
            ph = PIdle; m_err = 1'b0; m_frames = 0; gap_m = 0; tx_k = 0;
            pay.delete();
        end else begin
            case (ph)
                PIdle: if (start) begin
                    ph = PHunt; fwd = !f_layer; m_err = 1'b0;
                    pay.delete();
                end
                PHunt: if (word_vld && word_in == SYNC) ph = PLoad;
                PLoad: if (word_vld) begin
                    m_load_en = 1'b1; m_idx = pay.size(); m_data = word_in;
                    pay.push_back(word_in);
                    if (pay.size() == FW) begin
                        ph = fwd ? PXmit : PSort;
                        gap_m = fwd ? 1 : 0;
                        tx_k = 0; sort_cyc = 0;
                    end
                end
                PSort: begin
                    if (word_vld) m_err = 1'b1;
                    if (sort_finish) ph = PXmit;
                    else begin
                        sort_cyc++;
`ifdef ST_SEQ_TIMEOUT_EN
                        if (sort_cyc == TMO) begin ph = PIdle; m_err = 1'b1; end
`endif
                    end
                end
                PXmit: begin
                    if (word_vld) m_err = 1'b1;
                    if (gap_m > 0) gap_m--;
                    else begin
                        tx_k++;
                        if (tx_k == FW) begin
                            ph = PIdle; m_done = 1'b1; m_frames = (m_frames + 1) % 256;
                        end
                    end
                end
                default: ph = PIdle;
            endcase
        end
        #2;
        tx_exp = (ph == PXmit) && (gap_m == 0);
        chk("busy", 32'(busy), 32'(ph != PIdle));
        chk("load_en", 32'(load_en), 32'(m_load_en));
        if (m_load_en) begin
            chk("load_idx", 32'(load_idx), 32'(m_idx));
            chk("load_data", load_data, m_data);
        end
        chk("tx_out", 32'(tx_out), 32'(tx_exp));
        chk("tx_data", tx_data, !tx_exp ? 32'h0 : (fwd ? pay[tx_k] : st_data_in));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    end

    task automatic arm(input logic fl);
        @(negedge clk); start = 1'b1; f_layer = fl;
        @(negedge clk); start = 1'b0; f_layer = !fl;
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk); word_vld = 1'b1; word_in = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); word_vld = 1'b0; end
    endtask

    task automatic measure(input string name, input int want);
        int lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1; word_vld = 1'b0; sort_finish = 1'b0; #1;
            if (tx_out) begin lat = i; break; end
        end
        chk(name, lat, want);
    endtask

    task automatic wait_done(input string name, input int prior);
        int ntx = prior;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #2;
            if (tx_out) ntx++;
            if (done) seen = 1'b1;
        end
        chk({name, "_done"}, 32'(seen), 32'd1);
        chk({name, "_ntx"}, ntx, FW);
    endtask

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_en", 32'(load_en), 0);
        chk("rst_tx_out", 32'(tx_out), 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        rst = 1'b0;

        // Sort path; f_layer flips after start and must be ignored.
        arm(1'b1);
        send(SYNC);
        for (int i = 1; i <= 8; i++) send(32'(i));
        idle(5);
        sort_finish = 1'b1;
        measure("sort_lat", 1);
        wait_done("sort", 1);
        chk("sort_frame_cnt", 32'(frame_cnt), 1);

        // Forward path with 2-cycle gaps.
        arm(1'b0);
        send(SYNC);
        for (int i = 0; i < 8; i++) begin
            send(32'h1000_0000 + 32'(i * 17));
            if (i < 7) idle(2);
        end
        measure("fwd_lat", 2);
        wait_done("fwd", 1);
        chk("fwd_frame_cnt", 32'(frame_cnt), 2);

        // Hunt: junk words are dropped, first payload after SYNC is index 0.
        arm(1'b0);
        for (int i = 0; i < 4; i++) begin
            send(i < 3 ? 32'h5A5A_A5A5 + 32'(i) : SYNC);
            @(posedge clk); #2;
            chk("hunt_no_load", 32'(load_en), 0);
        end
        send(32'hDEAD_0000);
        @(posedge clk); #2;
        chk("hunt_first_en", 32'(load_en), 1);
        chk("hunt_first_idx", 32'(load_idx), 0);
        for (int i = 1; i < 8; i++) send(i == 3 ? SYNC : 32'hDEAD_0000 + 32'(i));
        measure("hunt_lat", 2);
        wait_done("hunt", 1);

        // Reset in the middle of LOAD at index 4.
        arm(1'b0);
        send(SYNC);
        for (int i = 0; i < 5; i++) send(32'hBEEF_0000 + 32'(i));
        @(posedge clk); #2;
        chk("mid_load_idx", 32'(load_idx), 4);
        @(negedge clk); rst = 1'b1; word_vld = 1'b0; #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_load_en", 32'(load_en), 0);
        chk("mid_rst_load_idx", 32'(load_idx), 0);
        chk("mid_rst_load_data", load_data, 0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        @(negedge clk); rst = 1'b0;
        arm(1'b0);
        send(SYNC);
        send(32'h7777_0000);
        @(posedge clk); #2;
        chk("post_rst_idx", 32'(load_idx), 0);
        for (int i = 1; i < 8; i++) send(32'h7777_0000 + 32'(i));
        measure("post_rst_lat", 2);
        wait_done("post_rst", 1);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 1);

        // Overrun during XMIT: err is sticky until the next start.
        arm(1'b0);
        send(SYNC);
        for (int i = 0; i < 8; i++) send(32'h3300_0000 + 32'(i));
        measure("ovr_lat", 2);
        word_vld = 1'b1; word_in = 32'h0BAD_0BAD;
        @(posedge clk); #1; word_vld = 1'b0; #1;
        chk("ovr_err", 32'(err), 1);
        wait_done("ovr", 2);
        idle(3);
        chk("ovr_err_sticky", 32'(err), 1);
        arm(1'b1);
        chk("ovr_err_clear", 32'(err), 0);

        // Sort frame that never sees sort_finish.
        send(SYNC);
        for (int i = 0; i < 8; i++) send(32'h4400_0000 + 32'(i));
        idle(1);
        ndone = 0;
        repeat (TMO + 10) begin
            @(posedge clk); #2;
            if (done) ndone++;
        end
`ifdef ST_SEQ_TIMEOUT_EN
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_err", 32'(err), 1);
`else
        chk("hold_busy", 32'(busy), 1);
        chk("hold_err", 32'(err), 0);
`endif
        chk("tmo_no_done", ndone, 0);
        chk("tmo_frame_cnt", 32'(frame_cnt), 2);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
